// File: rtl/haz_stall_ctrl_if.sv
// ============================================================================
// Module      : haz_stall_ctrl_if
// Description : Bundle of ID-stage hazard inputs and pipeline-control outputs
//               exchanged between the pipeline datapath and haz_stall_ctrl.
//               master = pipeline side (drives hazard info, consumes controls)
//               slave  = haz_stall_ctrl side
// Signals     : MemRead_i     ID/EX instruction is a load
//               Prev_RT_i     ID/EX load destination register
//               RSRT_i        IF/ID source registers {RS, RT}
//               UseRT_i       IF/ID instruction reads RT
//               BranchTaken_i branch resolved taken in ID
//               PCWrite_o     PC may update
//               IFIDWrite_o   IF/ID may load
//               IDEXBubble_o  ID/EX loads a nop
//               IFIDFlush_o   IF/ID loads a nop
//               Stall_o       stall active this cycle
//               StallCnt_o    saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface haz_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic                  MemRead_i;
  logic [REG_AW-1:0]     Prev_RT_i;
  logic [2*REG_AW-1:0]   RSRT_i;
  logic                  UseRT_i;
  logic                  BranchTaken_i;
  logic                  PCWrite_o;
  logic                  IFIDWrite_o;
  logic                  IDEXBubble_o;
  logic                  IFIDFlush_o;
  logic                  Stall_o;
  logic [CNT_W-1:0]      StallCnt_o;

  modport master (
    output MemRead_i, Prev_RT_i, RSRT_i, UseRT_i, BranchTaken_i,
    input  PCWrite_o, IFIDWrite_o, IDEXBubble_o, IFIDFlush_o, Stall_o, StallCnt_o
  );

  modport slave (
    input  MemRead_i, Prev_RT_i, RSRT_i, UseRT_i, BranchTaken_i,
    output PCWrite_o, IFIDWrite_o, IDEXBubble_o, IFIDFlush_o, Stall_o, StallCnt_o
  );
endinterface

`default_nettype wire

// File: rtl/haz_stall_ctrl.sv
// ============================================================================
// Module      : haz_stall_ctrl
// Description : Load-use hazard detector and stall/flush sequencer for a
//               five-stage pipeline. On a load-use hazard PC and IF/ID are
//               frozen and ID/EX is bubbled for LOAD_STALL cycles; a taken
//               ID-stage branch becomes an IF/ID flush when not stalling.
// Parameters  : REG_AW     register address width
//               LOAD_STALL stall cycles per hazard (1..15)
//               CNT_W      stall counter width
// Ports       : clk_i  rising-edge clock
//               rst_i  synchronous active-high reset
//               bus    haz_stall_ctrl_if.slave (hazard inputs, controls out)
// Options     : HAZ_STATS_EN - when defined, builds the saturating stall
//               counter behind StallCnt_o; otherwise StallCnt_o is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module haz_stall_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  haz_stall_ctrl_if.slave   bus
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Extra cycles owed after the detection cycle itself.
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL - 1);
  localparam bit         MULTI    = (LOAD_STALL > 1);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] rem;
  logic [3:0] rem_nxt;

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              hz;
  logic              stall;

  // --------------------------------------------------------------------------
  // Hazard detection: register 0 is never a real dependency, and RT only
  // matters when the IF/ID instruction actually reads it.
  // --------------------------------------------------------------------------
  assign rs = bus.RSRT_i[2*REG_AW-1:REG_AW];
  assign rt = bus.RSRT_i[REG_AW-1:0];

  assign hz = bus.MemRead_i
            & (bus.Prev_RT_i != '0)
            & ((bus.Prev_RT_i == rs) | (bus.UseRT_i & (bus.Prev_RT_i == rt)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The detection cycle is itself a stall cycle, so HOLD
  // only covers the remaining LOAD_STALL-1 cycles and is skipped entirely
  // for single-cycle stalls.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      ST_IDLE: begin
        if (hz && MULTI) begin
          state_nxt = ST_HOLD;
          rem_nxt   = REM_INIT;
        end
      end
      ST_HOLD: begin
        // hz is deliberately ignored here: the load is still in flight.
        rem_nxt = rem - 4'd1;
        if (rem == 4'd1) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rem_nxt   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Reset masks everything so downstream registers see a
  // clean, free-running pipeline while rst_i is high.
  // --------------------------------------------------------------------------
  always_comb begin
    stall = 1'b0;
    if (!rst_i) begin
      stall = (state == ST_HOLD) | hz;
    end
  end

  assign bus.Stall_o      = stall;
  assign bus.PCWrite_o    = ~stall;
  assign bus.IFIDWrite_o  = ~stall;
  assign bus.IDEXBubble_o = stall;
  // A frozen IF/ID must not be flushed; ID re-resolves the branch later.
  assign bus.IFIDFlush_o  = ~rst_i & bus.BranchTaken_i & ~stall;

  // --------------------------------------------------------------------------
  // Optional stall-cycle statistics
  // --------------------------------------------------------------------------
`ifdef HAZ_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign bus.StallCnt_o = stall_cnt;
`else
  assign bus.StallCnt_o = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: doc/haz_stall_ctrl.md
# haz_stall_ctrl

Parametrised load-use hazard detector and stall/flush sequencer for the five-stage pipeline, sitting between the ID stage and the PC, IF/ID and ID/EX pipeline registers. It compares the ID/EX load destination with the IF/ID source registers and ignores register 0. On a hazard it freezes PC and IF/ID and bubbles ID/EX for a configurable number of cycles, which covers multi-cycle data memory. It also converts a taken ID-stage branch into an IF/ID flush, and can count stall cycles for performance analysis.

## Interface
- REG_AW, 5, register address width
- LOAD_STALL, 1, stall cycles per load-use hazard (legal range 1..15)
- CNT_W, 16, stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- MemRead_i  in  1  instruction in ID/EX is a load
- Prev_RT_i  in  REG_AW  destination (RT) of the instruction in ID/EX
- RSRT_i  in  2*REG_AW  sources of the instruction in IF/ID, {RS, RT}
- UseRT_i  in  1  instruction in IF/ID reads RT as a source (0 for I-type ALU/load)
- BranchTaken_i  in  1  branch resolved taken in ID this cycle
- PCWrite_o  out  1  1 = PC may update
- IFIDWrite_o  out  1  1 = IF/ID may load
- IDEXBubble_o  out  1  1 = ID/EX loads control zeros (nop)
- IFIDFlush_o  out  1  1 = IF/ID loads a nop
- Stall_o  out  1  stall active this cycle
- StallCnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Hazard term: hz = MemRead_i & (Prev_RT_i != 0) & ((Prev_RT_i == RS) | (UseRT_i & (Prev_RT_i == RT))), with RS = RSRT_i[2*REG_AW-1:REG_AW] and RT = RSRT_i[REG_AW-1:0].
- FSM states:
  - IDLE: no stall in progress.
  - HOLD: counter rem (4 bits) holds the extra stall cycles still owed.
- IDLE with hz=1:
  - Stall_o=1, PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1 in the same cycle.
  - If LOAD_STALL>1: go to HOLD with rem=LOAD_STALL-1. Otherwise stay in IDLE.
- HOLD:
  - Stall outputs stay asserted; hz is not re-evaluated.
  - rem decrements each cycle. Exit to IDLE on the cycle in which rem==1.
  - The cycle after exit, hz is re-evaluated normally. It is 0 in a correct pipeline because the bubble now occupies ID/EX.
- Branch handling:
  - IFIDFlush_o = BranchTaken_i & ~Stall_o.
  - A branch taken during a stall is ignored; ID re-resolves it after the stall ends.
  - Hazard and branch in the same IDLE cycle: the hazard wins and IFIDFlush_o=0.
- Outputs when not stalled: PCWrite_o=1, IFIDWrite_o=1, IDEXBubble_o=0, Stall_o=0.
- StallCnt_o increments by 1 on every clock edge where Stall_o=1 and saturates at all-ones (no wrap).

## Timing
- Detection and stall outputs are combinational from the inputs and FSM state, so they are valid in the same cycle. State and counter update on the clk_i rising edge.
- Total stall length per hazard is exactly LOAD_STALL cycles.
- Reset values:
  - state=IDLE, rem=0, StallCnt_o=0.
  - PCWrite_o=1, IFIDWrite_o=1, IDEXBubble_o=0, IFIDFlush_o=0, Stall_o=0 (with inputs idle).
- Reset asserted mid-HOLD: state returns to IDLE at the next edge and the remaining stall is abandoned.
- While rst_i=1, outputs are forced to their reset values regardless of hz or BranchTaken_i.
- Back-to-back loads:
  - A second hazard is detected only once the FSM is back in IDLE.
  - No cycle exists where the FSM is in HOLD and a new stall is also counted twice.

## Configuration
- HAZ_STATS_EN
  - Defined: the CNT_W-bit saturating stall counter is built and StallCnt_o reports it.
  - Undefined: no counter flops; StallCnt_o is tied to 0. All other behaviour is identical.

## Test plan
- Load-use on RS, LOAD_STALL=1: MemRead_i=1, Prev_RT_i=8, RSRT_i={8,3}, UseRT_i=0 -> one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. The next cycle (MemRead_i=0) returns to normal. StallCnt_o=1.
- RT gating and register 0:
  - Prev_RT_i=3, RSRT_i={5,3}, UseRT_i=0 -> no stall.
  - Same with UseRT_i=1 -> stall.
  - Prev_RT_i=0, RSRT_i={0,0}, UseRT_i=1 -> no stall.
- LOAD_STALL=3: a single hazard cycle gives exactly 3 consecutive stall cycles even if MemRead_i drops after cycle 1. StallCnt_o goes 0->3.
- Branch priority:
  - BranchTaken_i=1 with no hazard -> IFIDFlush_o=1.
  - BranchTaken_i=1 with hz=1, or during HOLD -> IFIDFlush_o=0.
- Reset mid-HOLD: LOAD_STALL=4, assert rst_i in the 2nd stall cycle -> at the next edge all outputs are at reset values and StallCnt_o=0.
- Saturation (HAZ_STATS_EN, CNT_W=4): 20 stall cycles -> StallCnt_o=15. Without HAZ_STATS_EN -> StallCnt_o=0 throughout.
